// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the aging burst arbiter.
// Holds the FSM state enum, index width helper and key packing.
package arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Widest key the packing helper can build; callers truncate.
  localparam int KEY_MAX = 32;

  function automatic int index_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Key layout, MSB first: {request, boost, priority, rr_bit}.
  function automatic logic [KEY_MAX-1:0] pack_key(
    input logic               req,
    input logic               boost,
    input logic [KEY_MAX-1:0] prio,
    input int                 pw,
    input logic               rr
  );
    logic [KEY_MAX-1:0] hi;
    logic [KEY_MAX-1:0] lo;
    hi = {{(KEY_MAX-2){1'b0}}, req, boost};
    lo = {{(KEY_MAX-1){1'b0}}, rr};
    return (hi << (pw + 1)) | (prio << 1) | lo;
  endfunction

endpackage

// File: rtl/max_finder.sv
// Picks the largest compare key; ties go to the lowest index.
// Returns a one-hot location and the value carried by the winner.
module max_finder #(
  parameter int N             = 4,
  parameter int COMPARE_WIDTH = 5,
  parameter int VALUE_WIDTH   = 2
) (
  input  logic [N*COMPARE_WIDTH-1:0] i_compare,
  input  logic [N*VALUE_WIDTH-1:0]   i_value,
  output logic [N-1:0]               o_location,
  output logic [VALUE_WIDTH-1:0]     o_value
);

  logic [COMPARE_WIDTH-1:0] best;

  // Linear scan; strict greater-than keeps the lowest index on ties.
  always_comb begin
    best       = i_compare[COMPARE_WIDTH-1:0];
    o_value    = i_value[VALUE_WIDTH-1:0];
    o_location = '0;
    o_location[0] = 1'b1;
    for (int i = 1; i < N; i++) begin
      if (i_compare[i*COMPARE_WIDTH +: COMPARE_WIDTH] > best) begin
        best       = i_compare[i*COMPARE_WIDTH +: COMPARE_WIDTH];
        o_value    = i_value[i*VALUE_WIDTH +: VALUE_WIDTH];
        o_location = '0;
        o_location[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aging_burst_arbiter.sv
// Priority arbiter with round-robin tie-break and aging boost.
// Grants are registered and held until the burst signals i_done.
import arbiter_pkg::*;

module aging_burst_arbiter #(
  parameter  int REQUEST_WIDTH  = 4,
  parameter  int PRIORITY_WIDTH = 2,
  parameter  int AGE_LIMIT      = 7,
  localparam int AGE_WIDTH      = $clog2(AGE_LIMIT + 1),
  localparam int INDEX_WIDTH    = index_width(REQUEST_WIDTH)
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic [REQUEST_WIDTH-1:0]                i_request,
  input  logic [REQUEST_WIDTH*PRIORITY_WIDTH-1:0] i_priority,
  input  logic                                    i_done,
  output logic [REQUEST_WIDTH-1:0]                o_grant,
  output logic [INDEX_WIDTH-1:0]                  o_grant_index,
  output logic                                    o_busy
);

  localparam int CW = 1 + 1 + PRIORITY_WIDTH + 1;
  localparam int IW = INDEX_WIDTH;
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = AGE_WIDTH'(AGE_LIMIT);

  arb_state_e state_q, state_d;

  logic [REQUEST_WIDTH-1:0] grant_q, grant_d;
  logic [IW-1:0]            index_q, index_d;
  logic [IW-1:0]            rr_q, rr_d;
  logic [AGE_WIDTH-1:0]     age_q [REQUEST_WIDTH];
  logic [AGE_WIDTH-1:0]     age_d [REQUEST_WIDTH];

  logic [REQUEST_WIDTH*CW-1:0] key_flat;
  logic [REQUEST_WIDTH*IW-1:0] value_flat;
  logic [REQUEST_WIDTH-1:0]    win_loc;
  logic [IW-1:0]               win_idx;
  logic                        any_req;
  logic                        arb_en;
  logic                        clr_en;

  assign any_req = |i_request;

  // Build one arbitration key per requester; value is its index.
  always_comb begin
    key_flat   = '0;
    value_flat = '0;
    for (int i = 0; i < REQUEST_WIDTH; i++) begin
      key_flat[i*CW +: CW] = CW'(pack_key(
        i_request[i],
        age_q[i] == AGE_MAX,
        KEY_MAX'(i_priority[i*PRIORITY_WIDTH +: PRIORITY_WIDTH]),
        PRIORITY_WIDTH,
        IW'(i) > rr_q));
      value_flat[i*IW +: IW] = IW'(i);
    end
  end

  max_finder #(
    .N             (REQUEST_WIDTH),
    .COMPARE_WIDTH (CW),
    .VALUE_WIDTH   (IW)
  ) u_max (
    .i_compare  (key_flat),
    .i_value    (value_flat),
    .o_location (win_loc),
    .o_value    (win_idx)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; done without requests returns to idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (any_req) state_d = BUSY;
      BUSY: if (i_done && !any_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: when to arbitrate and when to drop the grant.
  always_comb begin
    arb_en = 1'b0;
    clr_en = 1'b0;
    unique case (state_q)
      IDLE: arb_en = any_req;
      BUSY: begin
        arb_en = i_done && any_req;
        clr_en = i_done && !any_req;
      end
      default: clr_en = 1'b1;
    endcase
  end

  // Grant, index and rr pointer load on arbitration.
  always_comb begin
    grant_d = grant_q;
    index_d = index_q;
    rr_d    = rr_q;
    if (arb_en) begin
      grant_d = win_loc;
      index_d = win_idx;
      rr_d    = win_idx;
    end else if (clr_en) begin
      grant_d = '0;
      index_d = '0;
    end
  end

  // Age counters: winners and idle requesters clear, waiters count.
  always_comb begin
    for (int i = 0; i < REQUEST_WIDTH; i++) begin
      age_d[i] = age_q[i];
      if (!i_request[i]) begin
        age_d[i] = '0;
      end else if (arb_en && win_loc[i]) begin
        age_d[i] = '0;
      end else if (!grant_q[i] && age_q[i] != AGE_MAX) begin
        age_d[i] = age_q[i] + AGE_WIDTH'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      grant_q <= '0;
      index_q <= '0;
      rr_q    <= '0;
      for (int i = 0; i < REQUEST_WIDTH; i++) age_q[i] <= '0;
    end else begin
      grant_q <= grant_d;
      index_q <= index_d;
      rr_q    <= rr_d;
      for (int i = 0; i < REQUEST_WIDTH; i++) age_q[i] <= age_d[i];
    end
  end

  assign o_grant       = grant_q;
  assign o_grant_index = index_q;
  assign o_busy        = (state_q == BUSY);

endmodule

// File: tb/tb_aging_burst_arbiter.sv
// Directed bench for aging_burst_arbiter (4 req, 2b prio, age 3).
// Steps are linear; each output is checked with an assertion.
module tb_aging_burst_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] prio = '0;
  logic       done = 1'b0;
  logic [3:0] grant;
  logic [1:0] gidx;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aging_burst_arbiter #(
    .REQUEST_WIDTH  (4),
    .PRIORITY_WIDTH (2),
    .AGE_LIMIT      (3)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_request     (req),
    .i_priority    (prio),
    .i_done        (done),
    .o_grant       (grant),
    .o_grant_index (gidx),
    .o_busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] eg,
                     input logic [1:0] ei, input logic eb);
    checks++;
    assert (grant === eg) else begin
      errors++;
      $error("FAIL %s grant: observed %b expected %b", tag, grant, eg);
    end
    checks++;
    assert (gidx === ei) else begin
      errors++;
      $error("FAIL %s index: observed %0d expected %0d", tag, gidx, ei);
    end
    checks++;
    assert (busy === eb) else begin
      errors++;
      $error("FAIL %s busy: observed %b expected %b", tag, busy, eb);
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 chk("reset", 4'b0000, 2'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_no_req", 4'b0000, 2'd0, 1'b0);

    // Mid-burst async reset, then one-cycle latency.
    req = 4'b0010;
    tick();
    chk("pre_rst_grant", 4'b0010, 2'd1, 1'b1);
    #3 rst = 1'b1;
    #1 chk("async_rst", 4'b0000, 2'd0, 1'b0);
    #1 rst = 1'b0;
    req = 4'b0001;
    #1 chk("no_comb_grant", 4'b0000, 2'd0, 1'b0);
    tick();
    chk("latency1", 4'b0001, 2'd0, 1'b1);
    done = 1'b1;
    req  = 4'b0000;
    tick();
    chk("to_idle1", 4'b0000, 2'd0, 1'b0);
    done = 1'b0;

    // Priority win, hold without done, boosted re-arbitration.
    prio = 8'b11_01_01_00;
    req  = 4'b1111;
    tick();
    chk("prio_win", 4'b1000, 2'd3, 1'b1);
    req = 4'b0111;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("prio_hold", 4'b1000, 2'd3, 1'b1);
    end
    done = 1'b1;
    tick();
    chk("prio_rearb", 4'b0010, 2'd1, 1'b1);
    req = 4'b0000;
    tick();
    chk("to_idle2", 4'b0000, 2'd0, 1'b0);
    done = 1'b0;

    // Single burst by req3 leaves the rr pointer at 3.
    req = 4'b1000;
    tick();
    chk("req3_only", 4'b1000, 2'd3, 1'b1);
    done = 1'b1;
    req  = 4'b0000;
    tick();
    chk("to_idle3", 4'b0000, 2'd0, 1'b0);

    // Round-robin with equal priority and done every cycle.
    prio = 8'b01_01_01_01;
    req  = 4'b1111;
    tick();
    chk("rr0", 4'b0001, 2'd0, 1'b1);
    tick();
    chk("rr1", 4'b0010, 2'd1, 1'b1);
    tick();
    chk("rr2", 4'b0100, 2'd2, 1'b1);
    tick();
    chk("rr3", 4'b1000, 2'd3, 1'b1);
    tick();
    chk("rr4", 4'b0001, 2'd0, 1'b1);
    req = 4'b0000;
    tick();
    chk("to_idle4", 4'b0000, 2'd0, 1'b0);
    done = 1'b0;

    // Aging: req0 (prio 0) eventually beats req1 (prio 3).
    prio = 8'b00_00_11_00;
    req  = 4'b0011;
    tick();
    chk("age_e1", 4'b0010, 2'd1, 1'b1);
    tick();
    chk("age_e2", 4'b0010, 2'd1, 1'b1);
    done = 1'b1;
    tick();
    chk("age_e3", 4'b0010, 2'd1, 1'b1);
    done = 1'b0;
    tick();
    chk("age_e4", 4'b0010, 2'd1, 1'b1);
    done = 1'b1;
    tick();
    chk("age_boost", 4'b0001, 2'd0, 1'b1);
    done = 1'b0;
    tick();
    chk("age_hold", 4'b0001, 2'd0, 1'b1);
    done = 1'b1;
    tick();
    chk("age_cleared", 4'b0010, 2'd1, 1'b1);
    req = 4'b0000;
    tick();
    chk("to_idle5", 4'b0000, 2'd0, 1'b0);
    done = 1'b0;

    // Idle return; done while idle is ignored.
    req = 4'b0100;
    tick();
    chk("req2_only", 4'b0100, 2'd2, 1'b1);
    done = 1'b1;
    req  = 4'b0000;
    tick();
    chk("idle_ret", 4'b0000, 2'd0, 1'b0);
    tick();
    chk("idle_done_a", 4'b0000, 2'd0, 1'b0);
    tick();
    chk("idle_done_b", 4'b0000, 2'd0, 1'b0);
    done = 1'b0;

    // Back-to-back re-grant of a lone requester.
    req = 4'b0001;
    tick();
    chk("b2b_first", 4'b0001, 2'd0, 1'b1);
    done = 1'b1;
    tick();
    chk("b2b_regrant", 4'b0001, 2'd0, 1'b1);
    done = 1'b0;
    tick();
    chk("b2b_hold", 4'b0001, 2'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aging_burst_arbiter.md
Name: aging_burst_arbiter

Overview:
- Shares one multi-cycle downstream resource (bus port, memory bank, shared pipeline) among REQUEST_WIDTH requesters.
- Arbitrates by priority with round-robin tie-break, plus an aging boost so low-priority requesters cannot starve.
- A grant is registered and locked until the downstream signals burst completion via i_done.

Parameters:
- REQUEST_WIDTH, 4, number of requesters (≥1).
- PRIORITY_WIDTH, 2, width of per-requester static priority; larger value means higher priority.
- AGE_LIMIT, 7, number of waiting cycles after which a requester is boosted (≥1).
- AGE_WIDTH, $clog2(AGE_LIMIT+1), age counter width; derived, not overridden.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, asynchronous, active-high
- i_request  input  REQUEST_WIDTH  per-requester request level
- i_priority  input  REQUEST_WIDTH x PRIORITY_WIDTH  per-requester static priority, sampled on the arbitration cycle
- i_done  input  1  downstream completion pulse for the current burst
- o_grant  output  REQUEST_WIDTH  one-hot registered grant, all-zero when idle
- o_grant_index  output  INDEX_WIDTH  binary index of the current grant (INDEX_WIDTH = 1 if REQUEST_WIDTH==1, else $clog2)
- o_busy  output  1  high while a grant is held

Behaviour:
- Clock and reset: single clock i_clk; i_rst is asynchronous, active-high.
- Reset values: o_grant=0, o_grant_index=0, o_busy=0, state=IDLE, rr pointer=0, all ages=0. Reset asserted mid-burst drops the grant immediately (asynchronously).
- FSM states: IDLE and BUSY.
  - IDLE: if i_request≠0 at edge t, then at t+1 o_grant=one-hot winner, o_grant_index=winner, o_busy=1, state=BUSY. Request-to-grant latency is exactly 1 cycle. If i_request=0, stay IDLE.
  - BUSY: the grant is held regardless of i_request (requester may drop early).
    - i_done=0: hold.
    - i_done=1 with i_request≠0: re-arbitrate in the same cycle. New grant at next edge, state stays BUSY, no idle bubble.
    - i_done=1 with i_request=0: go to IDLE, outputs clear next edge.
  - i_done in IDLE is ignored.
- Arbitration key per requester i: {i_request[i], boost[i], i_priority[i], rr_bit[i]}.
  - boost[i] = (age[i]==AGE_LIMIT).
  - rr_bit[i] = (i > rr pointer).
  - The maximum key wins. Exact key ties go to the lowest index. Requesters with i_request=0 never win.
- The rr pointer loads the winner index on every arbitration. The current grantee therefore loses ties against equal-key peers at re-arbitration.
- Age counters:
  - Per requester, increments by 1 each cycle that i_request[i]=1 and o_grant[i]=0; saturates at AGE_LIMIT.
  - Cleared when i_request[i]=0 or when i is granted (at the grant-load edge).
  - A held grantee's age stays 0.
- Simultaneous events: on a re-arbitration edge, the age clear of the new winner takes precedence over its increment. Ages of losers increment normally.
- REQUEST_WIDTH=1: the single requester is always the winner; o_grant_index=0.

Decomposition:
- Shared package arbiter_pkg holds:
  - arb_state_e enum {IDLE, BUSY};
  - an INDEX_WIDTH helper function;
  - the arbitration key packing function.
- The key comparison reuses the existing max_finder sub-module (N=REQUEST_WIDTH, COMPARE_WIDTH = 1+1+PRIORITY_WIDTH+1, value carries the index). Its location output gives the one-hot winner; index extraction uses the value field.
- The FSM, rr pointer and age counters live in aging_burst_arbiter itself.

Test Plan (REQUEST_WIDTH=4, PRIORITY_WIDTH=2, AGE_LIMIT=3):
1. Reset: assert i_rst mid-burst with o_grant=0010 -> o_grant=0000 and o_busy=0 immediately; after release, request=0001 -> grant 0001 exactly one cycle later.
2. Priority: request=1111, priority={3,1,1,0} for req3..0 -> grant 1000, held through 5 cycles without i_done even after request[3] drops; i_done -> next edge re-arbitration.
3. Round-robin: all priority 1, request=1111, pulse i_done each burst -> grant order 0001, 0010, 0100, 1000, 0001 with no idle cycle between bursts.
4. Aging: priority req1=3, req0=0, both requesting continuously, bursts of 2 cycles -> req0 age reaches 3 and it wins the next arbitration (boosted key beats priority 3 unboosted); its age resets to 0.
5. Idle return: single burst by req2, i_done with request=0000 -> o_grant=0000, o_busy=0 next edge; i_done pulses while IDLE -> no change.
6. Back-to-back re-request: req0 alone, i_done while request[0] still high -> grant 0001 re-issued the next edge, o_busy stays 1.
